// File: rtl/itp_frame_scheduler.sv
// itp_frame_scheduler: per-frame sequencer for the interpolation engine.
// It also arbitrates the shared SDRAM read-FIFO port between the display
// requester and the engine requester.
// Optional feature: define ITP_FRAME_SKIP_EN to launch a run only on every
// (FRAME_SKIP+1)-th eligible frame start.
module itp_frame_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 663168,
    parameter int unsigned START_DELAY = 2,
    parameter int unsigned FRAME_SKIP  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_frame_start,
    output logic        o_itp_start,
    input  logic        i_itp_finish,
    input  logic        i_disp_req,
    input  logic        i_itp_req,
    output logic        o_fifo_rd,
    output logic        o_grant_itp,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic        o_overrun,
    output logic        o_timeout,
    input  logic        i_clr_err
);

    // Parameter sanity checks at elaboration time.
    if (START_DELAY < 1) begin : g_bad_delay
        $error("START_DELAY must be >= 1");
    end
    if (FRAME_SKIP > 255) begin : g_bad_skip
        $error("FRAME_SKIP must fit the 8-bit skip counter");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1048576) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 20-bit timeout counter");
    end

    localparam int unsigned DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   delay_cnt;
    logic [19:0]     to_cnt;
    logic            skip_ok;
    logic            to_set;
    logic            grant_nxt;

`ifdef ITP_FRAME_SKIP_EN
    logic [7:0]      skip_cnt;

    assign skip_ok = (skip_cnt == 8'(FRAME_SKIP));

    // Skip counter: counts eligible frame starts seen in IDLE, clears on launch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skip_cnt <= '0;
        end else if (state == S_IDLE && i_frame_start && i_enable) begin
            skip_cnt <= skip_ok ? '0 : skip_cnt + 8'd1;
        end
    end
`else
    assign skip_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a START_DELAY of 1 bypasses DELAY entirely.
    always_comb begin
        state_nxt = state;
        to_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_frame_start && i_enable && skip_ok)
                    state_nxt = (START_DELAY <= 1) ? S_START : S_DELAY;
            end
            S_DELAY: begin
                if (delay_cnt == DW'(START_DELAY - 2)) state_nxt = S_START;
            end
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (i_itp_finish) begin
                    state_nxt = S_DONE;
                end else if (to_cnt == 20'(TIMEOUT_CYC - 1)) begin
                    state_nxt = S_IDLE;
                    to_set    = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        grant_nxt = (state_nxt == S_START) || (state_nxt == S_RUN);
    end

    // Delay and timeout counters; both sit at zero outside their own state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            delay_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            delay_cnt <= (state == S_DELAY) ? delay_cnt + DW'(1) : '0;
            to_cnt    <= (state == S_RUN)   ? to_cnt + 20'd1     : '0;
        end
    end

    // Registered outputs: busy/grant/read follow the state being entered,
    // start pulse and run count follow the state being left.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_grant_itp <= 1'b0;
            o_fifo_rd   <= 1'b0;
            o_itp_start <= 1'b0;
            o_frame_cnt <= '0;
            o_overrun   <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_busy      <= (state_nxt != S_IDLE);
            o_grant_itp <= grant_nxt;
            o_fifo_rd   <= grant_nxt ? i_itp_req : i_disp_req;
            o_itp_start <= (state == S_START);
            if (state == S_DONE) o_frame_cnt <= o_frame_cnt + 16'd1;
            if (i_frame_start && state != S_IDLE) o_overrun <= 1'b1;
            else if (i_clr_err)                   o_overrun <= 1'b0;
            if (to_set)         o_timeout <= 1'b1;
            else if (i_clr_err) o_timeout <= 1'b0;
        end
    end

endmodule
